// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu -- single-port load/store unit for a word-organised data memory.
//
// Accepts one byte/halfword/word load or store per request. The request is
// captured in IDLE and then runs through ACC (memory access), WR (write-back
// of the merged word, sub-word stores only) and FIN (one-cycle done pulse).
// Sub-word stores are done as read-modify-write so that only the addressed
// lane changes.
//
// Configuration macro:
//   LSU_ALIGN_CHK_EN  defined   : misaligned or size=11 requests are rejected
//                                 (done with err=1, no memory access).
//                     undefined : address low bits are forced to alignment,
//                                 size=11 behaves as word, err is always 0.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req        in   request strobe, sampled only in IDLE
//   we         in   1 = store, 0 = load
//   size       in   00 byte, 01 halfword, 10 word, 11 illegal
//   sext       in   loads: 1 = sign-extend, 0 = zero-extend
//   addr       in   byte address (AW+2 bits)
//   wdata      in   store data, right-aligned
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   err        out  valid with done, 1 = request rejected
//   rdata      out  extended load result, held until the next completed load
//   mem_addr   out  word address to the data memory
//   mem_rd     out  memory read strobe
//   mem_wr     out  memory write strobe
//   mem_wdata  out  memory write word
//   mem_rdata  in   memory read word, combinational from mem_addr
// ----------------------------------------------------------------------------
module lsu #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [AW+1:0] addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, WR, FIN} state_t;

    state_t        state, state_nxt;

    // Captured request
    logic          cap_we;
    logic [1:0]    cap_size;
    logic          cap_sext;
    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   merged;

    // Request as it will be captured (after alignment handling)
    logic [1:0]    acc_size;
    logic [AW+1:0] acc_addr;
    logic          reject;

    // Lane extraction / merge results
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_val;
    logic [31:0]   merge_val;

`ifdef LSU_ALIGN_CHK_EN
    logic          cap_err;

    always_comb begin
        acc_size = size;
        acc_addr = addr;
        reject   = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);
    end

    assign err = done & cap_err;
`else
    always_comb begin
        // size=11 is handled as a word access
        acc_size = (size == 2'b11) ? 2'b10 : size;
        acc_addr = addr;
        if (acc_size == 2'b01)
            acc_addr[0] = 1'b0;
        else if (acc_size == 2'b10)
            acc_addr[1:0] = 2'b00;
        reject   = 1'b0;
    end

    assign err = 1'b0;
`endif

    // Little-endian lane selection from the word read in ACC
    always_comb begin
        load_byte = mem_rdata[{cap_addr[1:0], 3'b000} +: 8];
        load_half = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (cap_size)
            2'b00:   load_val = {{24{cap_sext & load_byte[7]}}, load_byte};
            2'b01:   load_val = {{16{cap_sext & load_half[15]}}, load_half};
            default: load_val = mem_rdata;
        endcase
        merge_val = mem_rdata;
        if (cap_size == 2'b00)
            merge_val[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
        else if (cap_size == 2'b01)
            merge_val[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (req)
                    state_nxt = reject ? FIN : ACC;
            end
            ACC: begin
                mem_addr = cap_addr[AW+1:2];
                if (cap_we && cap_size == 2'b10) begin
                    mem_wr    = 1'b1;
                    mem_wdata = cap_wdata;
                    state_nxt = FIN;
                end else if (cap_we) begin
                    mem_rd    = 1'b1;   // read half of read-modify-write
                    state_nxt = WR;
                end else begin
                    mem_rd    = 1'b1;
                    state_nxt = FIN;
                end
            end
            WR: begin
                mem_addr  = cap_addr[AW+1:2];
                mem_wr    = 1'b1;
                mem_wdata = merged;
                state_nxt = FIN;
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Strobes are suppressed in the reset cycle itself so an abandoned
        // request can never touch memory.
        if (rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_size  <= 2'b00;
            cap_sext  <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            merged    <= '0;
            rdata     <= '0;
`ifdef LSU_ALIGN_CHK_EN
            cap_err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                cap_we    <= we;
                cap_size  <= acc_size;
                cap_sext  <= sext;
                cap_addr  <= acc_addr;
                cap_wdata <= wdata;
`ifdef LSU_ALIGN_CHK_EN
                cap_err   <= reject;
`endif
            end
            if (state == ACC && !cap_we)
                rdata <= load_val;
            if (state == ACC && cap_we)
                merged <= merge_val;
        end
    end

endmodule
